bram_capture_ctrl: RTL
======================

// Module: bram_capture_ctrl
// PURPOSE
// - Receiver capture sequencer: on each rising edge of the radar sync (sinc), writes NUM_SAMPLES
//   consecutive valid samples from the receiver datapath into a two-bank (ping-pong) BRAM.
// - Hands completed banks to the readout side (PS/DMA) with a ready/ack handshake; flags overruns.
// - Sits between the decimated receiver sample stream and the capture BRAM port A.
// PARAMETERS
// - DATA_WIDTH   32    sample / BRAM word width
// - ADDR_WIDTH   10    per-bank address width; BRAM address is ADDR_WIDTH+1 bits (MSB = bank)
// - NUM_SAMPLES  1000  samples per frame; legal range 1..2**ADDR_WIDTH
// PORTS
// - clk         in   1             system clock; all logic on posedge
// - rst         in   1             synchronous, active-high reset
// - enable      in   1             1 = arm on sync edges; 0 = finish current frame, then idle
// - sinc        in   1             radar sync, synchronous to clk, level signal
// - data_in     in   DATA_WIDTH    receiver sample
// - data_valid  in   1             data_in qualifier, any duty cycle
// - bram_en     out  1             BRAM enable (equals bram_we)
// - bram_we     out  1             BRAM write strobe, one per stored sample
// - bram_addr   out  ADDR_WIDTH+1  {bank, index}
// - bram_din    out  DATA_WIDTH    sample to write
// - buf_ready   out  1             level: at least one bank holds a complete frame
// - buf_bank    out  1             bank to read (oldest full bank); valid while buf_ready
// - buf_ack     in   1             1-cycle pulse: reader done with buf_bank; ignored if !buf_ready
// - overrun     out  1             1-cycle pulse: sync edge dropped because both banks full
// - frame_cnt   out  16            completed frames since reset, wraps 0xFFFF -> 0
// BEHAVIOUR
// - Reset: state IDLE, all outputs 0, full[1:0]=0, wr_bank=0, index=0, sync pipeline cleared.
// - Edge detect: sinc_d1<=sinc, sinc_d2<=sinc_d1; edge = sinc_d1 & ~sinc_d2 (2 clk after sinc rise).
//   Sinc high at reset release produces no edge.
// - FSM states: IDLE, ARMED, CAPTURE.
//   IDLE    -> ARMED   when enable=1.
//   ARMED   -> IDLE    when enable=0.
//   ARMED   -> CAPTURE on edge if full[wr_bank]=0; index<=0.
//   ARMED   stays      on edge if full[wr_bank]=1; overrun pulses 1 cycle, frame dropped.
//   CAPTURE -> ARMED/IDLE (per enable) on the cycle the NUM_SAMPLES-th sample is accepted.
// - CAPTURE: sample accepted each cycle data_valid=1; data_valid in the edge cycle or in IDLE/ARMED
//   is not stored. Write latency 1: sample accepted at t -> bram_we=1, bram_din=data_in(t),
//   bram_addr={wr_bank,index(t)} at t+1. index increments per accepted sample.
// - Frame completion: on last accept, full[wr_bank]<=1, wr_bank toggles, frame_cnt++ (all at t+1,
//   same cycle as the last bram_we).
// - Sync edges during CAPTURE are ignored (no restart, no overrun); enable=0 mid-frame does not abort.
// - Readout: buf_ready=|full. buf_bank = oldest full bank (tracked by rd_bank reg, toggles on ack).
//   buf_ack clears full[buf_bank]. Ack and completion in the same cycle: both applied; frees one
//   bank, fills the other.
// - Since capture only writes a non-full bank, the reader's bank is never overwritten.
// - rst mid-frame: partial frame discarded, full bits cleared, no buf_ready, no overrun.
// STRUCTURE
// - Shared package bram_capture_pkg: FSM state encoding (IDLE=2'd0, ARMED=2'd1, CAPTURE=2'd2),
//   FRAME_CNT_W=16.
// - One sub-module: bram_capture_bufmgr (full[1:0], wr_bank, rd_bank, buf_ready/buf_bank, ack logic).
// - Edge detector, FSM, index counter and write register stay in the top.
// TESTING (NUM_SAMPLES=8, ADDR_WIDTH=4 unless noted)
// - Basic frame: enable=1, sinc edge, data_valid=1 with data 0..7 -> 8 writes at addr 0x00..0x07,
//   din 0..7; buf_ready=1, buf_bank=0, frame_cnt=1.
// - Gapped valid: data_valid 1-0-1-0... -> exactly 8 writes, contiguous addresses, no write on low.
// - Ping-pong: two frames, no ack -> second frame at addr 0x10..0x17; third edge -> overrun pulse,
//   no writes; ack -> buf_bank=1, next edge captures to bank 0.
// - Edge in CAPTURE: second sinc edge at sample 3 -> ignored, frame completes 8 samples, no overrun.
// - Simultaneous ack and last write (bank0 full, capturing bank1) -> full=2'b10, buf_bank=1.
// - Reset mid-frame after 4 writes: buf_ready=0, frame_cnt=0; next frame starts at addr 0x00.

Source files
------------

// File: rtl/bram_capture_pkg.sv
// Shared definitions for the BRAM capture sequencer: FSM encoding and counter width.
package bram_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/bram_capture_bufmgr.sv
// Ping-pong bank bookkeeping: tracks which banks hold complete frames, the bank
// being filled next, and the oldest full bank offered to the reader.
module bram_capture_bufmgr
  import bram_capture_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_done,
  input  logic       buf_ack,
  output logic       wr_bank,
  output logic [1:0] full,
  output logic       buf_ready,
  output logic       buf_bank
);

  logic rd_bank;
  logic ack_ok;

  // Handshake: buf_ready is a level that stays high while any bank is full;
  // buf_bank names the oldest full bank and is only meaningful while buf_ready=1.
  // A one-cycle buf_ack releases buf_bank; an ack while buf_ready=0 is ignored.
  assign ack_ok    = buf_ack & (|full);
  assign buf_ready = |full;
  assign buf_bank  = rd_bank;

  // Capture only starts into a non-full bank and ack only hits a full one,
  // so the two updates below never target the same bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      if (frame_done) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= ~wr_bank;
      end
      if (ack_ok) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
    end
  end

endmodule

// File: rtl/bram_capture_ctrl.sv
// Capture sequencer: on each radar sync edge, writes NUM_SAMPLES valid samples
// into a ping-pong BRAM and hands completed banks to the readout side.
module bram_capture_ctrl
  import bram_capture_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int NUM_SAMPLES = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   sinc,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   data_valid,
  output logic                   bram_en,
  output logic                   bram_we,
  output logic [ADDR_WIDTH:0]    bram_addr,
  output logic [DATA_WIDTH-1:0]  bram_din,
  output logic                   buf_ready,
  output logic                   buf_bank,
  input  logic                   buf_ack,
  output logic                   overrun,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_SAMPLES - 1);

  state_t                state;
  logic                  sinc_d1;
  logic                  sinc_d2;
  logic [1:0]            sinc_vld;
  logic                  sync_edge;
  logic [ADDR_WIDTH-1:0] index;
  logic                  accept;
  logic                  frame_done;
  logic                  wr_bank;
  logic [1:0]            full;

  // sinc_vld masks the edge until both delay stages hold real samples, so a
  // sync already high when reset releases is not mistaken for a rising edge.
  assign sync_edge  = sinc_vld[1] & sinc_d1 & ~sinc_d2;
  assign accept     = (state == CAPTURE) & data_valid;
  assign frame_done = accept & (index == LAST_IDX);
  assign bram_en    = bram_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sinc_d1   <= 1'b0;
      sinc_d2   <= 1'b0;
      sinc_vld  <= 2'b00;
      index     <= '0;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_din  <= '0;
      overrun   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      sinc_d1  <= sinc;
      sinc_d2  <= sinc_d1;
      sinc_vld <= {sinc_vld[0], 1'b1};
      bram_we  <= accept;
      overrun  <= 1'b0;

      if (accept) begin
        bram_addr <= {wr_bank, index};
        bram_din  <= data_in;
        index     <= index + 1'b1;
      end

      if (frame_done) begin
        frame_cnt <= frame_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (enable) state <= ARMED;
        end
        ARMED: begin
          if (!enable) begin
            state <= IDLE;
          end else if (sync_edge) begin
            if (full[wr_bank]) begin
              overrun <= 1'b1;
            end else begin
              state <= CAPTURE;
              index <= '0;
            end
          end
        end
        CAPTURE: begin
          // Sync edges and enable=0 do not disturb a frame in progress.
          if (frame_done) state <= enable ? ARMED : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  bram_capture_bufmgr u_bufmgr (
    .clk        (clk),
    .rst        (rst),
    .frame_done (frame_done),
    .buf_ack    (buf_ack),
    .wr_bank    (wr_bank),
    .full       (full),
    .buf_ready  (buf_ready),
    .buf_bank   (buf_bank)
  );

endmodule
